// File: rtl/baccarat_datapath.sv
`default_nettype none
// ============================================================================
// baccarat_datapath: six card slots, live mod-10 scoring, 7-segment card
// displays and persistent BCD win/loss/tie tallies.   Rev 1.0
// ============================================================================
module baccarat_datapath (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] new_card,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    input  logic       tally_clr,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] pcard3,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [7:0] player_tally,
    output logic [7:0] dealer_tally,
    output logic [7:0] tie_tally
);

    // Slot order: 0..2 player cards 1..3, 3..5 dealer cards 1..3
    logic [3:0] card_q [6];
    logic [3:0] card_d [6];
    logic [5:0] load_w;
    logic       prev_end_q, prev_end_d;
    logic       game_end_w;
    logic [7:0] ptally_q, ptally_d;
    logic [7:0] dtally_q, dtally_d;
    logic [7:0] ttally_q, ttally_d;

    function automatic logic [3:0] card_val(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] a,
                                              input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
        if (s >= 5'd10) s = s - 5'd10;
        if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] c);
        logic [6:0] h;
        case (c)
            4'd1:    h = 7'b0001000;
            4'd2:    h = 7'b0100100;
            4'd3:    h = 7'b0110000;
            4'd4:    h = 7'b0011001;
            4'd5:    h = 7'b0010010;
            4'd6:    h = 7'b0000010;
            4'd7:    h = 7'b1111000;
            4'd8:    h = 7'b0000000;
            4'd9:    h = 7'b0010000;
            4'd10:   h = 7'b1000000;
            4'd11:   h = 7'b1100001;
            4'd12:   h = 7'b0011000;
            4'd13:   h = 7'b0001001;
            default: h = 7'b1111111;
        endcase
        return h;
    endfunction

    // Two-digit BCD increment that sticks at 99
    function automatic logic [7:0] bcd_inc(input logic [7:0] t);
        logic [7:0] r;
        if (t == 8'h99)
            r = t;
        else if (t[3:0] == 4'd9)
            r = {t[7:4] + 4'd1, 4'd0};
        else
            r = {t[7:4], t[3:0] + 4'd1};
        return r;
    endfunction

    assign load_w = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

    always_comb begin
        card_d = card_q;
        for (int i = 0; i < 6; i++) begin
            if (load_w[i]) card_d[i] = new_card;
        end
        if (!resetb) begin
            for (int i = 0; i < 6; i++) card_d[i] = 4'd0;
        end
    end

    // Game end is suppressed while reset is asserted so held lights count once after release
    assign game_end_w = resetb & (player_win_light | dealer_win_light) & ~prev_end_q;

    always_comb begin
        prev_end_d = resetb ? (player_win_light | dealer_win_light) : 1'b0;
        ptally_d   = ptally_q;
        dtally_d   = dtally_q;
        ttally_d   = ttally_q;
        if (tally_clr) begin
            ptally_d = 8'h00;
            dtally_d = 8'h00;
            ttally_d = 8'h00;
        end else if (game_end_w) begin
            if (player_win_light && dealer_win_light)
                ttally_d = bcd_inc(ttally_q);
            else if (player_win_light)
                ptally_d = bcd_inc(ptally_q);
            else
                dtally_d = bcd_inc(dtally_q);
        end
    end

    always_ff @(posedge slow_clock) begin
        card_q     <= card_d;
        prev_end_q <= prev_end_d;
        ptally_q   <= ptally_d;
        dtally_q   <= dtally_d;
        ttally_q   <= ttally_d;
    end

    assign pscore       = hand_score(card_q[0], card_q[1], card_q[2]);
    assign dscore       = hand_score(card_q[3], card_q[4], card_q[5]);
    assign pcard3       = card_q[2];
    assign HEX0         = seg7(card_q[0]);
    assign HEX1         = seg7(card_q[1]);
    assign HEX2         = seg7(card_q[2]);
    assign HEX3         = seg7(card_q[3]);
    assign HEX4         = seg7(card_q[4]);
    assign HEX5         = seg7(card_q[5]);
    assign player_tally = ptally_q;
    assign dealer_tally = dtally_q;
    assign tie_tally    = ttally_q;

endmodule
`default_nettype wire

// File: tb/tb_baccarat_datapath.sv
`default_nettype none
// ============================================================================
// tb_baccarat_datapath: directed and randomized checks against a card/tally
// reference model.   Rev 1.0
// ============================================================================
module tb_baccarat_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic [3:0] new_card = 4'd0;
    logic [5:0] ld = 6'd0;
    logic       pl = 1'b0, dl = 1'b0;
    logic       tally_clr = 1'b1;
    logic [3:0] pscore, dscore, pcard3;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [7:0] player_tally, dealer_tally, tie_tally;

    int checks = 0;
    int failures = 0;

    // Reference model: card codes per slot, tallies as plain integers
    int  m_card [6];
    int  m_pt, m_dt, m_tt;
    bit  m_prev;
    bit  tally_known = 0;

    baccarat_datapath dut (
        .slow_clock      (slow_clock),
        .resetb          (resetb),
        .new_card        (new_card),
        .load_pcard1     (ld[0]),
        .load_pcard2     (ld[1]),
        .load_pcard3     (ld[2]),
        .load_dcard1     (ld[3]),
        .load_dcard2     (ld[4]),
        .load_dcard3     (ld[5]),
        .player_win_light(pl),
        .dealer_win_light(dl),
        .tally_clr       (tally_clr),
        .pscore          (pscore),
        .dscore          (dscore),
        .pcard3          (pcard3),
        .HEX0            (HEX0),
        .HEX1            (HEX1),
        .HEX2            (HEX2),
        .HEX3            (HEX3),
        .HEX4            (HEX4),
        .HEX5            (HEX5),
        .player_tally    (player_tally),
        .dealer_tally    (dealer_tally),
        .tie_tally       (tie_tally)
    );

    always #5 slow_clock = ~slow_clock;

    function automatic int value_of(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic logic [6:0] seg_of(input int c);
        logic [6:0] t [16];
        t = '{7'b1111111, 7'b0001000, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b1000000, 7'b1100001,
              7'b0011000, 7'b0001001, 7'b1111111, 7'b1111111};
        return t[c];
    endfunction

    function automatic logic [7:0] bcd_of(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int ps, ds;
        ps = (value_of(m_card[0]) + value_of(m_card[1]) + value_of(m_card[2])) % 10;
        ds = (value_of(m_card[3]) + value_of(m_card[4]) + value_of(m_card[5])) % 10;
        chk("pscore", {4'd0, pscore}, 8'(ps));
        chk("dscore", {4'd0, dscore}, 8'(ds));
        chk("pcard3", {4'd0, pcard3}, 8'(m_card[2]));
        chk("HEX0", {1'b0, HEX0}, {1'b0, seg_of(m_card[0])});
        chk("HEX1", {1'b0, HEX1}, {1'b0, seg_of(m_card[1])});
        chk("HEX2", {1'b0, HEX2}, {1'b0, seg_of(m_card[2])});
        chk("HEX3", {1'b0, HEX3}, {1'b0, seg_of(m_card[3])});
        chk("HEX4", {1'b0, HEX4}, {1'b0, seg_of(m_card[4])});
        chk("HEX5", {1'b0, HEX5}, {1'b0, seg_of(m_card[5])});
        if (tally_known) begin
            chk("player_tally", player_tally, bcd_of(m_pt));
            chk("dealer_tally", dealer_tally, bcd_of(m_dt));
            chk("tie_tally", tie_tally, bcd_of(m_tt));
        end
    endtask

    // One clock: apply the rules to the inputs present at the edge, then compare
    task automatic tick();
        bit any, fire;
        @(posedge slow_clock);
        any  = pl | dl;
        fire = resetb && any && !m_prev;
        if (!resetb) begin
            for (int i = 0; i < 6; i++) m_card[i] = 0;
        end else begin
            for (int i = 0; i < 6; i++) if (ld[i]) m_card[i] = int'(new_card);
        end
        m_prev = resetb ? any : 1'b0;
        if (tally_clr) begin
            m_pt = 0; m_dt = 0; m_tt = 0;
            tally_known = 1;
        end else if (fire) begin
            if (pl && dl)  m_tt = (m_tt < 99) ? m_tt + 1 : 99;
            else if (pl)   m_pt = (m_pt < 99) ? m_pt + 1 : 99;
            else           m_dt = (m_dt < 99) ? m_dt + 1 : 99;
        end
        #1;
        check_all();
    endtask

    task automatic load(input logic [3:0] c, input logic [5:0] mask);
        new_card = c;
        ld = mask;
        tick();
        ld = 6'd0;
    endtask

    task automatic game(input logic p, input logic d, input int hold);
        pl = p; dl = d;
        for (int i = 0; i < hold; i++) tick();
        pl = 1'b0; dl = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 6; i++) m_card[i] = 0;
        m_pt = 0; m_dt = 0; m_tt = 0; m_prev = 0;

        // Reset and tally clear together
        tick();
        resetb = 1'b1; tally_clr = 1'b0;
        tick();
        chk("reset_hex0", {1'b0, HEX0}, 8'h7f);

        // Natural player hand
        load(4'd8, 6'b000001);
        load(4'd13, 6'b001000);
        load(4'd11, 6'b000010);
        load(4'd6, 6'b010000);
        chk("natural_pscore", {4'd0, pscore}, 8'd8);
        chk("natural_dscore", {4'd0, dscore}, 8'd6);

        // Third card with mod-10 wrap
        resetb = 1'b0; tick(); resetb = 1'b1;
        load(4'd7, 6'b000001);
        load(4'd9, 6'b000010);
        load(4'd8, 6'b000100);
        chk("wrap_pscore", {4'd0, pscore}, 8'd4);
        chk("wrap_pcard3", {4'd0, pcard3}, 8'd8);

        // Simultaneous load, then load against reset
        resetb = 1'b0; tick(); resetb = 1'b1;
        load(4'd5, 6'b001001);
        chk("dual_dscore", {4'd0, dscore}, 8'd5);
        resetb = 1'b0;
        load(4'd9, 6'b111111);
        resetb = 1'b1;
        chk("reset_prio_pscore", {4'd0, pscore}, 8'd0);
        load(4'd14, 6'b100000);
        load(4'd15, 6'b000100);

        // Three games after a clear
        tally_clr = 1'b1; tick(); tally_clr = 1'b0;
        game(1'b1, 1'b0, 4);
        game(1'b0, 1'b1, 2);
        game(1'b1, 1'b1, 3);
        chk("three_games_tie", tie_tally, 8'h01);

        // Ten player wins
        for (int i = 0; i < 10; i++) game(1'b1, 1'b0, 1);
        chk("ten_wins", player_tally, 8'h11);

        // Lights held across a reset count again on release
        pl = 1'b1; tick(); tick();
        resetb = 1'b0; tick(); tick();
        resetb = 1'b1; tick(); tick();
        pl = 1'b0; tick();

        // Saturation
        for (int i = 0; i < 95; i++) game(1'b1, 1'b0, 1);
        chk("saturate", player_tally, 8'h99);
        game(1'b1, 1'b0, 2);
        chk("saturate_hold", player_tally, 8'h99);

        // Clear beats a same-cycle game end
        dl = 1'b1; tally_clr = 1'b1; tick();
        tally_clr = 1'b0; dl = 1'b0; tick();
        chk("clr_prio", dealer_tally, 8'h00);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            new_card  = 4'($urandom_range(0, 15));
            ld        = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
            resetb    = ($urandom_range(0, 19) != 0);
            tally_clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) begin
                pl = 1'($urandom);
                dl = 1'($urandom);
            end
            tick();
        end
        ld = 6'd0; pl = 1'b0; dl = 1'b0; resetb = 1'b1; tally_clr = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/baccarat_datapath.md
# baccarat_datapath

Card-holding and scoring datapath on the receiving end of the Baccarat dealing state machine's load strobes. It latches the dealt card into one of six hand registers and returns the live `pscore`, `dscore` and `pcard3` that the state machine's draw decisions depend on. It also drives the six 7-segment card displays and keeps BCD win/loss/tie tallies across games.

## Interface
- No parameters.
- `slow_clock` in 1: the single clock, shared with the state machine.
- `resetb` in 1: synchronous, active-low reset.
- `new_card` in 4: card being dealt this cycle.
  - 1 = Ace, 2–10 = pips, 11 = Jack, 12 = Queen, 13 = King.
  - 0, 14 and 15 mean no card.
- `load_pcard1`, `load_pcard2`, `load_pcard3` in 1 each: latch `new_card` into that player slot.
- `load_dcard1`, `load_dcard2`, `load_dcard3` in 1 each: latch `new_card` into that dealer slot.
- `player_win_light`, `dealer_win_light` in 1 each: game result from the state machine; both high means a tie.
- `tally_clr` in 1: synchronous, active-high clear of the tallies.
- `pscore`, `dscore` out 4: hand score, 0–9.
- `pcard3` out 4: raw code held in the player's third-card slot.
- `HEX0`, `HEX1`, `HEX2` out 7: player cards 1–3, active-low segments.
- `HEX3`, `HEX4`, `HEX5` out 7: dealer cards 1–3, active-low segments.
- `player_tally`, `dealer_tally`, `tie_tally` out 8 each: two BCD digits, `[7:4]` tens and `[3:0]` units, range 00–99.

## Operation
- **Card slots:** six 4-bit registers.
  - On a rising edge with `resetb`=1 and `load_x`=1, slot x takes `new_card`.
  - Loads are independent. Several strobes high in the same cycle all load the same `new_card`.
  - Codes 14 and 15 are stored unchanged.
- **Card value:** codes 1–9 give their face value. Codes 0 and 10–15 give 0.
- **Scoring:** `pscore` = (pv1 + pv2 + pv3) mod 10, where pvN is the value of player card N. `dscore` is computed the same way over the dealer cards. Use a 5-bit intermediate sum (max 27) and reduce it by repeated subtraction of 10, or an equivalent method.
- **pcard3:** the raw slot code, not the card value. The state machine applies the dealer third-card rule to it.
- **Display encoding**, per card code:
  - 0, 14, 15: 1111111
  - 1 (Ace): 0001000
  - 2: 0100100
  - 3: 0110000
  - 4: 0011001
  - 5: 0010010
  - 6: 0000010
  - 7: 1111000
  - 8: 0000000
  - 9: 0010000
  - 10: 1000000
  - 11 (Jack): 1100001
  - 12 (Queen): 0011000
  - 13 (King): 0001001
- **Game-end detector:**
  - Register `prev_end` <= `player_win_light` | `dealer_win_light`.
  - A game end fires in the cycle where the OR is 1 and `prev_end` is 0.
  - On a game end: both lights high increments `tie_tally`; only the player light increments `player_tally`; only the dealer light increments `dealer_tally`.
  - Exactly one tally moves per game.
- **Tallies:**
  - Increments are BCD: units 9 wraps to 0 with a carry into tens.
  - Each tally saturates at 99; an increment at 99 leaves it at 99.
- **Reset behaviour:**
  - `resetb`=0 at an edge clears all six slots to 0 and clears `prev_end`.
  - `resetb` does NOT clear the tallies, because the state machine resets between games and the tallies must persist.
  - `tally_clr`=1 at an edge clears all three tallies to 00 and has priority over an increment in the same cycle.
  - Tallies are undefined until the first `tally_clr`. Top level ties `tally_clr` to the power-on reset.

## Timing
- **Reset values, after `resetb` low:** all slots 0, so `pscore`=0, `dscore`=0, `pcard3`=0 and HEX0–HEX5 = 1111111. Tallies are unchanged.
- **Load latency:** a strobe in cycle n updates the slot at the closing edge of cycle n. The score and HEX outputs are combinational from the slots and valid in cycle n+1. No extra pipeline stage is allowed: the state machine reads the scores in the cycle after `load_dcard2`.
- **Reset priority:** reset mid-game wins over any load strobe in the same cycle.
- **Tally latency:** the tally updates on the edge closing the cycle where the lights first rise. It is visible one cycle after that rise.
- **Held lights:** lights held high for many cycles count once.
- **Lights across reset:** lights falling and rising again are counted as a new game. Because `prev_end` clears on reset, lights still high across a reset are counted again once reset is released.

## Test plan
- **Reset:** drive `resetb`=0 for one edge -> all HEX = 1111111; `pscore`=`dscore`=`pcard3`=0.
- **Natural player hand:**
  - Stimulus: load pcard1=8 (Eight), dcard1=13 (King), pcard2=11 (Jack), dcard2=6, one per cycle.
  - Required: `pscore`=8, `dscore`=6, HEX0=0000000, HEX3=0001001.
- **Third cards with mod-10 wrap:**
  - Stimulus: load pcard1=7, pcard2=9, pcard3=8.
  - Required: `pscore`=4 (sum 24), `pcard3`=8.
- **Simultaneous load and reset priority:**
  - `new_card`=5 with `load_pcard1` and `load_dcard1` both high -> `pscore`=`dscore`=5.
  - A load together with `resetb`=0 -> slot stays 0.
- **Tallies:**
  - After `tally_clr`, run three games: player-only lights held 4 cycles, dealer-only, then both -> `player_tally`=01, `dealer_tally`=01, `tie_tally`=01.
  - Pulse player wins 10 times -> `player_tally`=8'h11.
- **Saturation and clear priority:**
  - Player tally at 99, one more player game -> stays 8'h99.
  - `tally_clr` in the same cycle as a game end -> 00.
